// File: rtl/nn_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// nn_seq_ctrl: weight-load / inference sequencer for one simple_nn. Rev 1.0
// Optional inference watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
// ==========================================================================
module nn_seq_ctrl #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned LoadBeats     = 41,
  parameter int unsigned InReqWidth    = 1813,
  parameter int unsigned NumOutputs    = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_load_i,
  input  logic [DataWidth-1:0]            wdata_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic                            shift_o,
  output logic [DataWidth-1:0]            weights_o,
  input  logic                            start_infer_i,
  output logic [InReqWidth-1:0]           nn_req_o,
  input  logic [InReqWidth-1:0]           nn_ack_i,
  input  logic [NumOutputs-1:0]           nn_req_i,
  output logic [NumOutputs-1:0]           nn_ack_o,
  input  logic [DataWidth*NumOutputs-1:0] nn_actv_i,
  output logic [DataWidth*NumOutputs-1:0] result_o,
  output logic                            result_valid_o,
  output logic                            busy_o,
  output logic                            loaded_o,
  output logic                            error_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FIRE    = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int unsigned     BeatW    = (LoadBeats > 1) ? $clog2(LoadBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LoadBeats - 1);

  state_e                          state_q, state_d;
  logic [BeatW-1:0]                beat_q, beat_d;
  logic                            shift_q, shift_d;
  logic [DataWidth-1:0]            weights_q, weights_d;
  logic                            loaded_q, loaded_d;
  logic                            error_q, error_d;
  logic [InReqWidth-1:0]           pending_q, pending_d;
  logic [NumOutputs-1:0]           got_q, got_d;
  logic [NumOutputs-1:0]           ack_q, ack_d;
  logic [DataWidth*NumOutputs-1:0] result_q, result_d;

`ifdef NN_SEQ_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);

  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_d;
  logic              in_infer;
  logic              timeout;

  // Timer idles at zero so it is already cleared on the first FIRE cycle.
  assign in_infer = (state_q == S_FIRE) || (state_q == S_COLLECT);
  assign timeout  = in_infer && (timer_q == TimerW'(TimeoutCycles - 1));
  assign timer_d  = in_infer ? (timer_q + 1'b1) : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`else
  if (TimeoutCycles > 0) begin : g_no_timeout
  end
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shift_d   = 1'b0;
    weights_d = weights_q;
    loaded_d  = loaded_q;
    error_d   = error_q;
    pending_d = pending_q;
    got_d     = got_q;
    ack_d     = '0;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          state_d  = S_LOAD;
          loaded_d = 1'b0;
          beat_d   = '0;
          error_d  = 1'b0;
        end else if (start_infer_i) begin
          if (loaded_q) begin
            state_d   = S_FIRE;
            pending_d = '1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (wvalid_i) begin
          shift_d   = 1'b1;
          weights_d = wdata_i;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d  = S_IDLE;
            loaded_d = 1'b1;
            beat_d   = '0;
          end
        end
      end
      S_FIRE: begin
        pending_d = pending_q & ~nn_ack_i;
        if (pending_d == '0) begin
          state_d = S_COLLECT;
          got_d   = '0;
        end
      end
      S_COLLECT: begin
        for (int k = 0; k < NumOutputs; k++) begin
          if (nn_req_i[k] && !got_q[k]) begin
            result_d[k*DataWidth +: DataWidth] = nn_actv_i[k*DataWidth +: DataWidth];
            ack_d[k] = 1'b1;
            got_d[k] = 1'b1;
          end
        end
        if (&got_d) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef NN_SEQ_TIMEOUT_EN
    // Abort drops every handshake; captures already made stay in result_o.
    if (timeout) begin
      state_d   = S_IDLE;
      pending_d = '0;
      ack_d     = '0;
      result_d  = result_q;
      error_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      shift_q   <= 1'b0;
      weights_q <= '0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
      pending_q <= '0;
      got_q     <= '0;
      ack_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shift_q   <= shift_d;
      weights_q <= weights_d;
      loaded_q  <= loaded_d;
      error_q   <= error_d;
      pending_q <= pending_d;
      got_q     <= got_d;
      ack_q     <= ack_d;
      result_q  <= result_d;
    end
  end

  assign wready_o       = (state_q == S_LOAD);
  assign shift_o        = shift_q;
  assign weights_o      = weights_q;
  assign nn_req_o       = pending_q;
  assign nn_ack_o       = ack_q;
  assign result_o       = result_q;
  assign result_valid_o = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign loaded_o       = loaded_q;
  assign error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_nn_seq_ctrl: self-checking bench for nn_seq_ctrl. Rev 1.0
// ==========================================================================
module tb_nn_seq_ctrl;
  localparam int DW  = 8;
  localparam int LB  = 41;
  localparam int IRW = 1813;
  localparam int NO  = 4;
  localparam int TO  = 16;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              start_load_i, wvalid_i, wready_o, shift_o, start_infer_i;
  logic [DW-1:0]     wdata_i, weights_o;
  logic [IRW-1:0]    nn_req_o, nn_ack_i;
  logic [NO-1:0]     nn_req_i, nn_ack_o;
  logic [DW*NO-1:0]  nn_actv_i, result_o;
  logic              result_valid_o, busy_o, loaded_o, error_o;

  nn_seq_ctrl #(
    .DataWidth(DW), .LoadBeats(LB), .InReqWidth(IRW), .NumOutputs(NO), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_load_i(start_load_i), .wdata_i(wdata_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .shift_o(shift_o), .weights_o(weights_o),
    .start_infer_i(start_infer_i), .nn_req_o(nn_req_o), .nn_ack_i(nn_ack_i),
    .nn_req_i(nn_req_i), .nn_ack_o(nn_ack_o), .nn_actv_i(nn_actv_i), .result_o(result_o),
    .result_valid_o(result_valid_o), .busy_o(busy_o), .loaded_o(loaded_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int          vcnt    = 0;
  logic [39:0] shq[$];
  logic [39:0] exq[$];

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) begin
    if (shift_o) shq.push_back({cyc, weights_o});
    if (result_valid_o) vcnt <= vcnt + 1;
  end

  typedef struct {
    bit pre; bit sl; bit si;
    bit busy; bit wready; bit req_any; bit err; bit loaded;
  } vec_t;
  vec_t tbl[6];

  logic [IRW-1:0]   pend, ackv;
  int               grp[IRW];
  logic [NO-1:0]    gotm, r, expack;
  logic [DW*NO-1:0] a, model_res;
  int               cnt, vb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_load_i = 0; start_infer_i = 0; wvalid_i = 0; wdata_i = '0;
    nn_ack_i = '0; nn_req_i = '0; nn_actv_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 0;
    tick(); tick();
    reset_i = 1;
    model_res = '0;
  endtask

  function automatic logic [IRW-1:0] rand_vec();
    logic [IRW-1:0] v;
    for (int i = 0; i < IRW; i++) v[i] = ($urandom_range(0, 7) != 0);
    return v;
  endfunction

  // Expected shift stream: each accepted byte appears on weights_o the cycle after its accept edge.
  task automatic do_load(input logic [DW-1:0] base, input bit gaps);
    int nmis;
    int g;
    shq.delete(); exq.delete();
    start_load_i = 1; tick(); start_load_i = 0;
    for (int i = 0; i < LB; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin wvalid_i = 0; wdata_i = DW'($urandom); tick(); end
      end
      wvalid_i = 1; wdata_i = DW'(base + i); tick();
      exq.push_back({cyc, DW'(base + i)});
    end
    wvalid_i = 0; wdata_i = '0;
    chk("load_loaded", loaded_o, 1);
    chk("load_busy", busy_o, 0);
    tick();
    chk("load_shift_count", shq.size(), LB);
    nmis = 0;
    for (int i = 0; i < exq.size(); i++)
      if (i >= shq.size() || shq[i] !== exq[i]) nmis++;
    chk("load_seq_mismatch", nmis, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          pre sl si busy wrdy req err loaded
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 1, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 1, 0, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 1, 1, 0, 0, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 0, 0, 1};

    do_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_loaded", loaded_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_shift", shift_o, 0);
    chk("rst_weights", weights_o, 0);
    chk("rst_req", $countones(nn_req_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_valid", result_valid_o, 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      if (tbl[t].pre) do_load(8'h40, 1'b0);
      start_load_i = tbl[t].sl; start_infer_i = tbl[t].si;
      tick();
      start_load_i = 0; start_infer_i = 0;
      chk($sformatf("tbl%0d_busy", t), busy_o, tbl[t].busy);
      chk($sformatf("tbl%0d_wready", t), wready_o, tbl[t].wready);
      chk($sformatf("tbl%0d_req", t), |nn_req_o, tbl[t].req_any);
      chk($sformatf("tbl%0d_error", t), error_o, tbl[t].err);
      chk($sformatf("tbl%0d_loaded", t), loaded_o, tbl[t].loaded);
    end

    // Load with gaps, then a scripted inference with scrambled input-layer acks.
    do_reset();
    do_load(8'h01, 1'b1);
    for (int i = 0; i < IRW; i++) grp[i] = $urandom_range(0, 4);
    vb = vcnt;
    start_infer_i = 1; tick(); start_infer_i = 0;
    chk("inf_req_all", $countones(nn_req_o), IRW);
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < IRW; i++) begin
        ackv[i] = (grp[i] <= j);
        pend[i] = (grp[i] > j);
      end
      nn_ack_i = ackv; tick();
      chk($sformatf("inf_req_step%0d", j), $countones(nn_req_o ^ pend), 0);
    end
    nn_ack_i = '0;
    nn_req_i = 4'b0101; nn_actv_i = {8'hEE, 8'h33, 8'hEE, 8'h11}; tick();
    chk("inf_ack_0101", nn_ack_o, 4'b0101);
    chk("inf_valid_early", result_valid_o, 0);
    tick();
    chk("inf_ack_repeat", nn_ack_o, 4'b0000);
    nn_req_i = 4'b1010; nn_actv_i = {8'h44, 8'hAA, 8'h22, 8'hAA}; tick();
    chk("inf_ack_1010", nn_ack_o, 4'b1010);
    chk("inf_valid", result_valid_o, 1);
    chk("inf_result", result_o, 32'h44332211);
    idle_inputs(); tick();
    chk("inf_valid_drop", result_valid_o, 0);
    chk("inf_busy", busy_o, 0);
    tick();
    chk("inf_valid_pulses", vcnt - vb, 1);
    chk("inf_result_hold", result_o, 32'h44332211);
    model_res = 32'h44332211;

    // Random inferences against a set-based model of the handshakes.
    for (int run = 0; run < 4; run++) begin
      start_infer_i = 1; tick(); start_infer_i = 0;
      pend = '1;
      chk("rnd_req_init", $countones(nn_req_o ^ pend), 0);
      cnt = 0;
      while (pend != '0 && cnt < 64) begin
        ackv = rand_vec(); nn_ack_i = ackv; tick(); cnt++;
        pend = pend & ~ackv;
        chk("rnd_req_retire", $countones(nn_req_o ^ pend), 0);
      end
      nn_ack_i = '0;
      if (pend != '0) bound_fail("rnd_fire_bound");
      gotm = '0; cnt = 0;
      while (gotm != 4'hF && cnt < 64) begin
        r = NO'($urandom_range(0, 15) | $urandom_range(0, 15));
        a = $urandom;
        nn_req_i = r; nn_actv_i = a; tick(); cnt++;
        expack = r & ~gotm;
        for (int k = 0; k < NO; k++)
          if (expack[k]) model_res[k*DW +: DW] = a[k*DW +: DW];
        gotm = gotm | r;
        chk("rnd_ack", nn_ack_o, expack);
        chk("rnd_valid", result_valid_o, gotm == 4'hF);
        if (gotm == 4'hF) chk("rnd_result", result_o, model_res);
      end
      if (gotm != 4'hF) bound_fail("rnd_collect_bound");
      idle_inputs(); tick();
      chk("rnd_valid_drop", result_valid_o, 0);
      chk("rnd_busy", busy_o, 0);
    end

    // Reset in COLLECT aborts everything and forgets the loaded weights.
    start_infer_i = 1; tick(); start_infer_i = 0;
    nn_ack_i = '1; tick(); nn_ack_i = '0;
    nn_req_i = 4'b0001; nn_actv_i = 32'h0000005A; tick();
    idle_inputs(); reset_i = 0; tick();
    chk("rstc_busy", busy_o, 0);
    chk("rstc_loaded", loaded_o, 0);
    chk("rstc_error", error_o, 0);
    chk("rstc_ack", nn_ack_o, 0);
    chk("rstc_req", $countones(nn_req_o), 0);
    chk("rstc_result", result_o, 0);
    chk("rstc_wready", wready_o, 0);
    reset_i = 1;
    start_infer_i = 1; tick(); start_infer_i = 0;
    chk("rstc_infer_err", error_o, 1);
    chk("rstc_infer_idle", busy_o, 0);
    chk("rstc_infer_req", $countones(nn_req_o), 0);
    start_load_i = 1; tick(); start_load_i = 0;
    chk("err_clear_on_load", error_o, 0);
    chk("err_clear_busy", busy_o, 1);

`ifdef NN_SEQ_TIMEOUT_EN
    do_reset();
    do_load(8'h30, 1'b0);
    vb = vcnt;
    start_infer_i = 1; tick(); start_infer_i = 0;
    repeat (15) tick();
    chk("to_req_held", $countones(nn_req_o), IRW);
    tick();
    chk("to_req_drop", $countones(nn_req_o), 0);
    chk("to_error", error_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_ack", nn_ack_o, 0);
    chk("to_loaded", loaded_o, 1);
    tick();
    chk("to_no_valid", vcnt - vb, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
